// File: rtl/counter_display_pkg.sv
// Shared constants, FSM encoding and segment decode for the counter display block.
// Segment patterns are active low, bit order {g,f,e,d,c,b,a}.
package counter_display_pkg;

    localparam int unsigned BCD_DIGITS = 5;
    localparam int unsigned BIN_WIDTH  = 16;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCommit
    } conv_state_e;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: one add-3/shift step per clock, 16 steps per conversion.
// done pulses for one cycle in StCommit while bcd holds the finished result.
module bin2bcd_serial
    import counter_display_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [BIN_WIDTH-1:0]      bin,
    output logic                      busy,
    output logic                      done,
    output logic [4*BCD_DIGITS-1:0]   bcd
);

    localparam int unsigned BcdW = 4 * BCD_DIGITS;
    localparam int unsigned SrW  = BcdW + BIN_WIDTH;

    conv_state_e    state_q, state_d;
    logic [SrW-1:0] sr_q, sr_d, sr_adj;
    logic [4:0]     cnt_q, cnt_d;

    // Add 3 to every BCD nibble >= 5 so the following shift carries correctly.
    always_comb begin
        sr_adj = sr_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (sr_q[BIN_WIDTH + 4*i +: 4] >= 4'd5) begin
                sr_adj[BIN_WIDTH + 4*i +: 4] = sr_q[BIN_WIDTH + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sr_d    = {{BcdW{1'b0}}, bin};
                    cnt_d   = 5'(BIN_WIDTH);
                    state_d = StShift;
                end
            end
            StShift: begin
                sr_d  = sr_adj << 1;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StCommit);
    assign bcd  = sr_q[SrW-1 -: BcdW];

endmodule

// File: rtl/counter_display.sv
// Shows a 16-bit count on a 4-digit multiplexed seven-segment display.
// Detects value changes, converts serially to BCD, commits atomically and scans digits.
module counter_display
    import counter_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV    = 2500,
    parameter bit          LZ_BLANK    = 1'b1,
    parameter int unsigned MAX_DISPLAY = 9999
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] value,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [15:0] bcd,
    output logic        ovf,
    output logic        busy
);

    localparam int unsigned PrescW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [15:0]            last_value_q;
    logic                   start;
    logic                   conv_busy;
    logic                   conv_done;
    logic [4*BCD_DIGITS-1:0] conv_bcd;
    logic [15:0]            bcd_q;
    logic                   ovf_q;
    logic [PrescW-1:0]      presc_q, presc_d;
    logic [1:0]             digit_q, digit_d;
    logic [3:0]             an_q, an_d;
    logic [6:0]             seg_q, seg_d;
    logic [3:0]             lz_mask;
    logic [3:0]             sel_nib;
    logic                   presc_tc;
    logic                   unused_msd;

    // Changes arriving while the converter is busy are picked up on the next idle edge.
    assign start = !conv_busy && (value != last_value_q);

    bin2bcd_serial u_bin2bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .bin     (value),
        .busy    (conv_busy),
        .done    (conv_done),
        .bcd     (conv_bcd)
    );

    // Fifth nibble only matters for values above 9999, which display as dashes anyway.
    assign unused_msd = ^conv_bcd[4*BCD_DIGITS-1:16];

    always_comb begin
        presc_tc = (presc_q == PrescW'(SCAN_DIV - 1));
        presc_d  = presc_tc ? '0 : presc_q + PrescW'(1);
        digit_d  = presc_tc ? digit_q + 2'd1 : digit_q;
        an_d     = ~(4'b0001 << digit_d);
        sel_nib  = bcd_q[{digit_d, 2'b00} +: 4];

        // lz_mask[i]: digit i and all digits above it are zero; digit 0 is never blanked.
        lz_mask[3] = (bcd_q[15:12] == 4'd0);
        lz_mask[2] = lz_mask[3] && (bcd_q[11:8] == 4'd0);
        lz_mask[1] = lz_mask[2] && (bcd_q[7:4] == 4'd0);
        lz_mask[0] = 1'b0;

        if (ovf_q) begin
            seg_d = SEG_DASH;
        end else if (LZ_BLANK && lz_mask[digit_d]) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = seg_decode(sel_nib);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_value_q <= '0;
            bcd_q        <= '0;
            ovf_q        <= 1'b0;
            presc_q      <= '0;
            digit_q      <= '0;
            an_q         <= 4'b1111;
            seg_q        <= SEG_BLANK;
        end else begin
            if (start) begin
                last_value_q <= value;
            end
            if (conv_done) begin
                bcd_q <= conv_bcd[15:0];
                ovf_q <= (32'(last_value_q) > MAX_DISPLAY);
            end
            presc_q <= presc_d;
            digit_q <= digit_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = 1'b1;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;
    assign busy = conv_busy;

endmodule

// File: tb/tb_counter_display.sv
// Scoreboard bench for counter_display: commits checked by a monitor, display checked per scan.
module tb_counter_display;

    logic        clk;
    logic        reset_n;
    logic [15:0] value;

    logic [3:0]  an_a, an_b;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [15:0] bcd_a, bcd_b;
    logic        ovf_a, ovf_b;
    logic        busy_a, busy_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [16:0] sb_q[$];
    logic        busy_prev = 1'b0;
    logic        rst_seen  = 1'b0;

    counter_display #(.SCAN_DIV(4), .LZ_BLANK(1'b1), .MAX_DISPLAY(9999)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .value   (value),
        .an      (an_a),
        .seg     (seg_a),
        .dp      (dp_a),
        .bcd     (bcd_a),
        .ovf     (ovf_a),
        .busy    (busy_a)
    );

    counter_display #(.SCAN_DIV(1), .LZ_BLANK(1'b0), .MAX_DISPLAY(9999)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .value   (value),
        .an      (an_b),
        .seg     (seg_b),
        .dp      (dp_b),
        .bcd     (bcd_b),
        .ovf     (ovf_b),
        .busy    (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Monitor: a falling busy on a non-reset edge is a commit.
    always @(posedge clk) rst_seen = reset_n;

    always @(negedge clk) begin
        logic [16:0] exp;
        if (rst_seen && busy_prev && !busy_a) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL commit_unexpected: got bcd=%h ovf=%b, required no commit",
                         bcd_a, ovf_a);
            end else begin
                exp = sb_q.pop_front();
                check("commit_a", {15'd0, ovf_a, bcd_a}, {15'd0, exp});
                check("commit_b", {15'd0, ovf_b, bcd_b}, {15'd0, exp});
            end
        end
        busy_prev = busy_a;
    end

    task automatic wait_drain(input int budget, input string name, output int used);
        used = 0;
        while (sb_q.size() > 0 && used < budget) begin
            @(negedge clk);
            used++;
        end
        check(name, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic measure_busy(input string name, input int exp_len);
        int cnt = 0;
        @(negedge clk);
        while (busy_a && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check(name, 32'(cnt), 32'(exp_len));
    endtask

    task automatic check_disp(input bit which, input logic [6:0] e3, input logic [6:0] e2,
                              input logic [6:0] e1, input logic [6:0] e0, input string name);
        logic [6:0] got[4];
        logic [6:0] exp[4];
        logic [3:0] seen = 4'b0000;
        logic [3:0] a;
        logic [6:0] s;
        bit         bad_an = 1'b0;
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        for (int i = 0; i < 4; i++) got[i] = 7'h7f;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            a = which ? an_b : an_a;
            s = which ? seg_b : seg_a;
            case (a)
                4'b1110: begin got[0] = s; seen[0] = 1'b1; end
                4'b1101: begin got[1] = s; seen[1] = 1'b1; end
                4'b1011: begin got[2] = s; seen[2] = 1'b1; end
                4'b0111: begin got[3] = s; seen[3] = 1'b1; end
                default: bad_an = 1'b1;
            endcase
        end
        check({name, "_an_onehot"}, {27'd0, bad_an, seen}, {27'd0, 1'b0, 4'b1111});
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_d%0d", name, i), {25'd0, got[i]}, {25'd0, exp[i]});
        end
    endtask

    initial begin
        int used;
        reset_n = 1'b0;
        value   = 16'd0;
        repeat (3) @(negedge clk);

        // 1: reset values, scan order, no conversion for value 0
        check("rst_an",   {28'd0, an_a},  {28'd0, 4'b1111});
        check("rst_seg",  {25'd0, seg_a}, {25'd0, 7'h7f});
        check("rst_dp",   {31'd0, dp_a},  32'd1);
        check("rst_bcd",  {16'd0, bcd_a}, 32'd0);
        check("rst_ovf",  {31'd0, ovf_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        reset_n = 1'b1;
        check("first_cycle_an", {28'd0, an_a}, {28'd0, 4'b1111});
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            check($sformatf("scan_an_%0d", n), {28'd0, an_a},
                  {28'd0, ~(4'b0001 << ((n / 4) % 4))});
            check($sformatf("idle_busy_%0d", n), {31'd0, busy_a}, 32'd0);
        end
        check_disp(1'b0, 7'h7f, 7'h7f, 7'h7f, 7'h40, "zero_a");
        check_disp(1'b1, 7'h40, 7'h40, 7'h40, 7'h40, "zero_b");

        // 2: 3550
        value = 16'd3550;
        sb_q.push_back({1'b0, 16'h3550});
        measure_busy("busy_len_3550", 17);
        wait_drain(10, "drain_3550", used);
        check_disp(1'b0, 7'h30, 7'h12, 7'h12, 7'h40, "d3550_a");

        // 3: 5, with and without leading-zero blanking
        @(negedge clk);
        value = 16'd5;
        sb_q.push_back({1'b0, 16'h0005});
        wait_drain(30, "drain_5", used);
        check_disp(1'b0, 7'h7f, 7'h7f, 7'h7f, 7'h12, "d5_a");
        check_disp(1'b1, 7'h40, 7'h40, 7'h40, 7'h12, "d5_b");

        // 4: overflow then back
        @(negedge clk);
        value = 16'd10000;
        sb_q.push_back({1'b1, 16'h0000});
        wait_drain(30, "drain_10000", used);
        check_disp(1'b0, 7'h3f, 7'h3f, 7'h3f, 7'h3f, "d10000_a");
        check_disp(1'b1, 7'h3f, 7'h3f, 7'h3f, 7'h3f, "d10000_b");
        @(negedge clk);
        value = 16'd9999;
        sb_q.push_back({1'b0, 16'h9999});
        wait_drain(30, "drain_9999", used);
        @(negedge clk);
        value = 16'd5500;
        sb_q.push_back({1'b0, 16'h5500});
        wait_drain(30, "drain_5500", used);
        check_disp(1'b0, 7'h12, 7'h12, 7'h40, 7'h40, "d5500_a");

        // 5: change during a conversion
        @(negedge clk);
        value = 16'd5;
        sb_q.push_back({1'b0, 16'h0005});
        repeat (5) @(negedge clk);
        value = 16'd10;
        sb_q.push_back({1'b0, 16'h0010});
        wait_drain(35, "drain_change", used);
        check_disp(1'b0, 7'h7f, 7'h7f, 7'h79, 7'h40, "d10_a");

        // 6: reset during SHIFT
        @(negedge clk);
        value = 16'd3550;
        repeat (5) @(negedge clk);
        check("mid_busy", {31'd0, busy_a}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_an",   {28'd0, an_a},  {28'd0, 4'b1111});
        check("abort_seg",  {25'd0, seg_a}, {25'd0, 7'h7f});
        check("abort_bcd",  {16'd0, bcd_a}, 32'd0);
        check("abort_ovf",  {31'd0, ovf_a}, 32'd0);
        check("abort_busy", {31'd0, busy_a}, 32'd0);
        check("abort_dp",   {31'd0, dp_a},  32'd1);
        reset_n = 1'b1;
        sb_q.push_back({1'b0, 16'h3550});
        measure_busy("busy_len_restart", 17);
        wait_drain(10, "drain_restart", used);
        check_disp(1'b0, 7'h30, 7'h12, 7'h12, 7'h40, "restart_a");

        repeat (3) @(negedge clk);
        check("final_busy", {31'd0, busy_a}, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
